// File: rtl/sopc_counter_cpu_jtag_mon_mem_pkg.sv
// Shared definitions for the JTAG debug monitor RAM: FSM encoding,
// JTAG command codes and jdo field positions.
package sopc_counter_cpu_jtag_mon_mem_pkg;

    localparam int MON_ADDR_W = 8;

    // FSM states kept as plain constants so the encoding is stable in netlists
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_J_ACC  = 3'd1;
    localparam logic [2:0] ST_J_CAP  = 3'd2;
    localparam logic [2:0] ST_C_ACC  = 3'd3;
    localparam logic [2:0] ST_C_DONE = 3'd4;

    // Decoded JTAG commands
    localparam logic [1:0] CMD_ADDR    = 2'd0;  // load MonAReg only
    localparam logic [1:0] CMD_ADDR_RD = 2'd1;  // load MonAReg, read there
    localparam logic [1:0] CMD_RD      = 2'd2;  // read at MonAReg, then increment
    localparam logic [1:0] CMD_WR      = 2'd3;  // write at MonAReg, then increment

    // jdo field layout
    localparam int JDO_W         = 38;
    localparam int JDO_RD_BIT    = 34;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;

    // Latched JTAG command (address goes straight into MonAReg)
    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] wdata;
    } jcmd_t;

    function automatic logic cmd_is_read(input logic [1:0] op);
        return (op == CMD_ADDR_RD) || (op == CMD_RD);
    endfunction

endpackage

// File: rtl/sopc_counter_cpu_jtag_mon_mem_if.sv
// CPU-side Avalon-MM slave bus of the monitor RAM.
interface sopc_counter_cpu_jtag_mon_mem_if
    import sopc_counter_cpu_jtag_mon_mem_pkg::*;
#(
    parameter int ADDR_W = MON_ADDR_W
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/sopc_counter_cpu_jtag_mon_mem_ram.sv
// Single-port byte-enabled RAM with registered read data (1-cycle latency).
// Read-before-write: q shows the old word on a write cycle.
module sopc_counter_cpu_jtag_mon_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_q
);
    logic [31:0] r_mem [0:(1<<ADDR_W)-1];

    // Byte-lane write and registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        o_q <= r_mem[i_addr];
    end
endmodule

// File: rtl/sopc_counter_cpu_jtag_mon_mem.sv
// JTAG debug monitor RAM shared between the JTAG debug engine and a CPU
// Avalon-MM slave. JTAG commands win over CPU accesses; a command that
// arrives while a CPU access is in flight waits in a one-deep pending slot.
// action_a with a read does not advance MonAReg; only no_action_a reads
// and action_b writes post-increment it.
module sopc_counter_cpu_jtag_mon_mem
    import sopc_counter_cpu_jtag_mon_mem_pkg::*;
#(
    parameter int ADDR_W = MON_ADDR_W
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [JDO_W-1:0]                    jdo,
    input  logic                                take_action_ocimem_a,
    input  logic                                take_no_action_ocimem_a,
    input  logic                                take_action_ocimem_b,
    sopc_counter_cpu_jtag_mon_mem_if.slave      avs,
    output logic [31:0]                         MonDReg,
    output logic                                monitor_ready,
    output logic                                monitor_error
);
    logic [2:0]        r_state;
    jcmd_t             r_cmd;
    logic              r_pend;
    logic [ADDR_W-1:0] r_mon_a;
    logic [31:0]       r_mon_d;
    logic              r_ready;
    logic              r_error;

    logic              w_any_cmd;
    logic              w_accept;
    logic              w_drop;
    jcmd_t             w_new_cmd;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [3:0]        w_ram_be;
    logic [31:0]       w_ram_wdata;
    logic [31:0]       w_q;
    logic              w_unused_jdo;

    assign w_any_cmd    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_accept     = w_any_cmd &  r_ready;
    assign w_drop       = w_any_cmd & ~r_ready;
    assign w_unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

    // Decode simultaneous pulses with priority action_a > no_action_a > action_b
    always_comb begin
        w_new_cmd.op    = CMD_WR;
        w_new_cmd.wdata = jdo[JDO_WDATA_LSB +: 32];
        if (take_action_ocimem_a)
            w_new_cmd.op = jdo[JDO_RD_BIT] ? CMD_ADDR_RD : CMD_ADDR;
        else if (take_no_action_ocimem_a)
            w_new_cmd.op = CMD_RD;
    end

    // Command acceptance, error tracking and the access FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_pend  <= 1'b0;
            r_mon_a <= '0;
            r_mon_d <= '0;
            r_ready <= 1'b1;
            r_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd   <= w_new_cmd;
                r_ready <= 1'b0;
                if (take_action_ocimem_a) begin
                    r_mon_a <= jdo[JDO_ADDR_LSB +: ADDR_W];
                    r_error <= 1'b0;
                end
                // CPU access in flight: park the command until IDLE
                if (r_state != ST_IDLE) r_pend <= 1'b1;
            end else if (w_drop) begin
                r_error <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept || r_pend) begin
                        r_state <= ST_J_ACC;
                        r_pend  <= 1'b0;
                    end else if (avs.avs_read || avs.avs_write) begin
                        r_state <= ST_C_ACC;
                    end
                end
                ST_J_ACC: begin
                    if (cmd_is_read(r_cmd.op)) begin
                        r_state <= ST_J_CAP;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                    if (r_cmd.op == CMD_RD || r_cmd.op == CMD_WR)
                        r_mon_a <= r_mon_a + 1'b1;
                end
                ST_J_CAP: begin
                    r_mon_d <= w_q;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                ST_C_ACC:  r_state <= ST_C_DONE;
                ST_C_DONE: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM port steering: JTAG in J_ACC, CPU in C_ACC, otherwise idle read
    always_comb begin
        w_ram_addr  = r_mon_a;
        w_ram_we    = 1'b0;
        w_ram_be    = 4'hF;
        w_ram_wdata = r_cmd.wdata;
        if (r_state == ST_C_ACC) begin
            w_ram_addr  = avs.avs_address;
            w_ram_we    = avs.avs_write;
            w_ram_be    = avs.avs_byteenable;
            w_ram_wdata = avs.avs_writedata;
        end else if (r_state == ST_J_ACC) begin
            w_ram_we    = (r_cmd.op == CMD_WR);
        end
    end

    sopc_counter_cpu_jtag_mon_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_q     (w_q)
    );

    assign avs.avs_waitrequest = (r_state != ST_C_DONE);
    assign avs.avs_readdata    = (r_state == ST_C_DONE) ? w_q : 32'h0;
    assign MonDReg             = r_mon_d;
    assign monitor_ready       = r_ready;
    assign monitor_error       = r_error;
endmodule

// File: tb/tb_sopc_counter_cpu_jtag_mon_mem.sv
// Self-checking bench: directed scenarios plus randomized JTAG/CPU traffic
// checked against a word-array model of the monitor RAM and MonAReg.
module tb_sopc_counter_cpu_jtag_mon_mem;
    import sopc_counter_cpu_jtag_mon_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta, tna, tbb;
    logic [31:0] mon_d;
    logic        rdy, err;

    sopc_counter_cpu_jtag_mon_mem_if #(.ADDR_W(8)) bus ();

    sopc_counter_cpu_jtag_mon_mem #(.ADDR_W(8)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta),
        .take_no_action_ocimem_a (tna),
        .take_action_ocimem_b    (tbb),
        .avs                     (bus.slave),
        .MonDReg                 (mon_d),
        .monitor_ready           (rdy),
        .monitor_error           (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_mem [256];
    logic [7:0]  m_addr;

    function automatic logic [37:0] jdo_addr(input logic [7:0] a, input logic rd);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        j[34]    = rd;
        j[37:35] = 3'($urandom);
        return j;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3]  = d;
        j[37:35] = 3'($urandom);
        j[2:0]   = 3'($urandom);
        return j;
    endfunction

    // One-cycle JTAG pulse; returns #1 into cycle T+1
    task automatic pulse(input logic a, input logic na, input logic b, input logic [37:0] j);
        @(posedge clk); #1;
        ta = a; tna = na; tbb = b; jdo = j;
        @(posedge clk); #1;
        ta = 0; tna = 0; tbb = 0; jdo = '0;
    endtask

    // Bounded Avalon transfer; nlow = waitrequest-low cycles seen (0 = timeout)
    task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] be, output logic [31:0] rd, output int nlow);
        nlow = 0; rd = '0;
        @(posedge clk); #1;
        bus.avs_address = a; bus.avs_read = !wr; bus.avs_write = wr;
        bus.avs_writedata = d; bus.avs_byteenable = be;
        for (int i = 0; i < 20 && nlow == 0; i++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) begin nlow++; rd = bus.avs_readdata; end
            @(posedge clk); #1;
        end
        bus.avs_read = 0; bus.avs_write = 0;
    endtask

    task automatic test_reset;
        reset_n = 0; ta = 0; tna = 0; tbb = 0; jdo = '0;
        bus.avs_address = '0; bus.avs_read = 0; bus.avs_write = 0;
        bus.avs_writedata = '0; bus.avs_byteenable = '0;
        repeat (3) @(negedge clk);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", err); end
        checks++; if (mon_d !== 32'h0) begin failures++; $display("FAIL reset_mondreg got=%h exp=0", mon_d); end
        checks++; if (bus.avs_waitrequest !== 1'b1) begin failures++; $display("FAIL reset_waitreq got=%b exp=1", bus.avs_waitrequest); end
        checks++; if (bus.avs_readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=0", bus.avs_readdata); end
        @(posedge clk); #1; reset_n = 1;
        m_addr = '0;
    endtask

    task automatic test_cpu_fill;
        logic [31:0] d, rd; int n, tot;
        tot = 0;
        for (int a = 0; a < 256; a++) begin
            d = $urandom;
            cpu_access(1'b1, 8'(a), d, 4'hF, rd, n);
            m_mem[a] = d; tot += n;
        end
        checks++; if (tot !== 256) begin failures++; $display("FAIL fill_handshakes got=%0d exp=256", tot); end
        for (int k = 0; k < 8; k++) begin
            logic [7:0] a;
            a = 8'($urandom);
            cpu_access(1'b0, a, '0, 4'h0, rd, n);
            checks++; if (n !== 1 || rd !== m_mem[a]) begin failures++; $display("FAIL fill_readback a=%h got=%h exp=%h n=%0d", a, rd, m_mem[a], n); end
        end
    endtask

    task automatic test_jtag_write;
        logic [31:0] rd; int n;
        pulse(1, 0, 0, jdo_addr(8'h10, 1'b0));
        @(negedge clk); checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL addr_ready_t1 got=%b exp=0", rdy); end
        @(negedge clk); checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL addr_ready_t2 got=%b exp=1", rdy); end
        m_addr = 8'h10;
        pulse(0, 0, 1, jdo_data(32'hDEADBEEF));
        @(negedge clk); checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL wr_ready_t1 got=%b exp=0", rdy); end
        @(negedge clk); checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL wr_ready_t2 got=%b exp=1", rdy); end
        m_mem[m_addr] = 32'hDEADBEEF; m_addr++;
        pulse(0, 0, 1, jdo_data(32'h12345678));
        repeat (2) @(negedge clk);
        m_mem[m_addr] = 32'h12345678; m_addr++;
        cpu_access(1'b0, 8'h10, '0, 4'h0, rd, n);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_ram10 got=%h exp=deadbeef", rd); end
        cpu_access(1'b0, 8'h11, '0, 4'h0, rd, n);
        checks++; if (rd !== 32'h12345678) begin failures++; $display("FAIL wr_incr_ram11 got=%h exp=12345678", rd); end
    endtask

    task automatic test_jtag_read;
        pulse(1, 0, 0, jdo_addr(8'h10, 1'b1));
        @(negedge clk); checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rd_ready_t1 got=%b exp=0", rdy); end
        @(negedge clk); checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rd_ready_t2 got=%b exp=0", rdy); end
        @(negedge clk); checks++; if (rdy !== 1'b1 || mon_d !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_t3 ready=%b mondreg=%h exp 1/deadbeef", rdy, mon_d); end
        m_addr = 8'h10;
    endtask

    task automatic test_wrap;
        pulse(1, 0, 0, jdo_addr(8'hFF, 1'b0));
        repeat (2) @(negedge clk);
        m_addr = 8'hFF;
        pulse(0, 1, 0, '0);
        repeat (3) @(negedge clk);
        checks++; if (rdy !== 1'b1 || mon_d !== m_mem[8'hFF]) begin failures++; $display("FAIL wrap_read_ff got=%h exp=%h", mon_d, m_mem[8'hFF]); end
        m_addr++;
        pulse(0, 1, 0, '0);
        repeat (3) @(negedge clk);
        checks++; if (mon_d !== m_mem[m_addr]) begin failures++; $display("FAIL wrap_read_00 got=%h exp=%h", mon_d, m_mem[m_addr]); end
        m_addr++;
    endtask

    task automatic test_drop_error;
        logic [7:0] victim; logic [31:0] rd; int n;
        victim = m_addr + 8'd1;
        @(posedge clk); #1; tna = 1;
        @(posedge clk); #1; tna = 0; tbb = 1; jdo = jdo_data(~m_mem[victim]);
        @(posedge clk); #1; tbb = 0; jdo = '0;
        @(negedge clk); checks++; if (rdy !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL drop_t2 ready=%b error=%b exp 0/1", rdy, err); end
        @(negedge clk); checks++; if (rdy !== 1'b1 || mon_d !== m_mem[m_addr]) begin failures++; $display("FAIL drop_read got=%h exp=%h", mon_d, m_mem[m_addr]); end
        m_addr++;
        pulse(1, 0, 0, jdo_addr(8'h40, 1'b0));
        @(negedge clk); checks++; if (err !== 1'b0) begin failures++; $display("FAIL drop_clear got=%b exp=0", err); end
        @(negedge clk);
        m_addr = 8'h40;
        cpu_access(1'b0, victim, '0, 4'h0, rd, n);
        checks++; if (rd !== m_mem[victim]) begin failures++; $display("FAIL drop_no_write got=%h exp=%h", rd, m_mem[victim]); end
    endtask

    task automatic test_priority;
        logic [7:0] x, old; logic [31:0] rd; int n;
        x = 8'($urandom_range(0, 127)) + 8'h80; old = m_addr;
        pulse(1, 1, 1, jdo_addr(x, 1'b0));
        @(negedge clk); checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL prio_t1 got=%b exp=0", rdy); end
        @(negedge clk); checks++; if (rdy !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL prio_t2 ready=%b error=%b exp 1/0", rdy, err); end
        m_addr = x;
        pulse(0, 1, 0, '0);
        repeat (3) @(negedge clk);
        checks++; if (mon_d !== m_mem[x]) begin failures++; $display("FAIL prio_addr got=%h exp=%h", mon_d, m_mem[x]); end
        m_addr++;
        cpu_access(1'b0, old, '0, 4'h0, rd, n);
        checks++; if (rd !== m_mem[old]) begin failures++; $display("FAIL prio_no_write got=%h exp=%h", rd, m_mem[old]); end
    endtask

    task automatic test_collision;
        logic [31:0] got; int nlow;
        pulse(1, 0, 0, jdo_addr(8'h10, 1'b0));
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        tbb = 1; jdo = jdo_data(32'hCAFEF00D);
        bus.avs_address = 8'h10; bus.avs_read = 1; bus.avs_write = 0;
        @(posedge clk); #1; tbb = 0; jdo = '0;
        nlow = 0; got = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!bus.avs_waitrequest) begin nlow++; got = bus.avs_readdata; end
            @(posedge clk); #1;
            if (nlow != 0) bus.avs_read = 0;
        end
        bus.avs_read = 0;
        m_mem[8'h10] = 32'hCAFEF00D; m_addr = 8'h11;
        checks++; if (nlow !== 1) begin failures++; $display("FAIL coll_wait_low got=%0d exp=1", nlow); end
        checks++; if (got !== 32'hCAFEF00D) begin failures++; $display("FAIL coll_readdata got=%h exp=cafef00d", got); end
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL coll_ready got=%b exp=1", rdy); end
    endtask

    task automatic test_pending;
        logic [31:0] d, old, rd; logic [7:0] a; int n; logic seen;
        a = m_addr; d = $urandom; old = m_mem[a];
        @(posedge clk); #1; bus.avs_address = a; bus.avs_read = 1;
        @(posedge clk); #1; tbb = 1; jdo = jdo_data(d);
        @(posedge clk); #1; tbb = 0; jdo = '0;
        @(negedge clk);
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL pend_ready_low got=%b exp=0", rdy); end
        checks++; if (bus.avs_waitrequest !== 1'b0 || bus.avs_readdata !== old) begin failures++; $display("FAIL pend_cpu_first got=%h exp=%h", bus.avs_readdata, old); end
        @(posedge clk); #1; bus.avs_read = 0;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (rdy) seen = 1;
        end
        checks++; if (!seen || err !== 1'b0) begin failures++; $display("FAIL pend_complete ready_seen=%b error=%b exp 1/0", seen, err); end
        m_mem[a] = d; m_addr++;
        cpu_access(1'b0, a, '0, 4'h0, rd, n);
        checks++; if (rd !== d) begin failures++; $display("FAIL pend_written got=%h exp=%h", rd, d); end
    endtask

    task automatic test_random;
        logic [31:0] d, rd; logic [7:0] a; logic [3:0] be; logic r; int n, op;
        for (int k = 0; k < 80; k++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    d = $urandom;
                    pulse(0, 0, 1, jdo_data(d));
                    @(negedge clk); checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rand_wr_t1 got=%b exp=0", rdy); end
                    @(negedge clk); checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL rand_wr_t2 got=%b exp=1", rdy); end
                    m_mem[m_addr] = d; m_addr++;
                end
                1: begin
                    pulse(0, 1, 0, '0);
                    repeat (2) @(negedge clk);
                    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rand_rd_t2 got=%b exp=0", rdy); end
                    @(negedge clk);
                    checks++; if (rdy !== 1'b1 || mon_d !== m_mem[m_addr]) begin failures++; $display("FAIL rand_rd a=%h got=%h exp=%h ready=%b", m_addr, mon_d, m_mem[m_addr], rdy); end
                    m_addr++;
                end
                2: begin
                    a = 8'($urandom); r = 1'($urandom);
                    pulse(1, 0, 0, jdo_addr(a, r));
                    @(negedge clk); checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rand_addr_t1 got=%b exp=0", rdy); end
                    @(negedge clk);
                    if (r) begin
                        @(negedge clk);
                        checks++; if (rdy !== 1'b1 || mon_d !== m_mem[a]) begin failures++; $display("FAIL rand_addr_rd a=%h got=%h exp=%h", a, mon_d, m_mem[a]); end
                    end else begin
                        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL rand_addr_t2 got=%b exp=1", rdy); end
                    end
                    m_addr = a;
                end
                3: begin
                    a = 8'($urandom); d = $urandom; be = 4'($urandom);
                    cpu_access(1'b1, a, d, be, rd, n);
                    checks++; if (n !== 1) begin failures++; $display("FAIL rand_cpu_wr_hs got=%0d exp=1", n); end
                    for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
                end
                default: begin
                    a = 8'($urandom);
                    cpu_access(1'b0, a, '0, 4'h0, rd, n);
                    checks++; if (n !== 1 || rd !== m_mem[a]) begin failures++; $display("FAIL rand_cpu_rd a=%h got=%h exp=%h n=%0d", a, rd, m_mem[a], n); end
                end
            endcase
        end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rand_error got=%b exp=0", err); end
    endtask

    task automatic test_reset_mid;
        int lows;
        @(posedge clk); #1; tna = 1;
        @(posedge clk); #1; tna = 0; tbb = 1; jdo = jdo_data(32'h5A5A5A5A);
        @(posedge clk); #1; tbb = 0; jdo = '0;
        repeat (2) @(negedge clk);
        m_addr++;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL rstmid_pre_error got=%b exp=1", err); end
        pulse(0, 1, 0, '0);
        @(posedge clk); #1; reset_n = 0;
        @(negedge clk);
        checks++; if (rdy !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL rstmid_flags ready=%b error=%b exp 1/0", rdy, err); end
        checks++; if (mon_d !== 32'h0) begin failures++; $display("FAIL rstmid_mondreg got=%h exp=0", mon_d); end
        checks++; if (bus.avs_waitrequest !== 1'b1 || bus.avs_readdata !== 32'h0) begin failures++; $display("FAIL rstmid_avs wait=%b rdata=%h exp 1/0", bus.avs_waitrequest, bus.avs_readdata); end
        @(posedge clk); #1; reset_n = 1;
        lows = 0;
        repeat (4) begin @(negedge clk); if (rdy !== 1'b1) lows++; end
        checks++; if (lows !== 0) begin failures++; $display("FAIL rstmid_no_pulse low_cycles=%0d exp=0", lows); end
        m_addr = 8'h00;
        pulse(0, 1, 0, '0);
        repeat (3) @(negedge clk);
        checks++; if (mon_d !== m_mem[0]) begin failures++; $display("FAIL rstmid_addr0 got=%h exp=%h", mon_d, m_mem[0]); end
        m_addr++;
    endtask

    initial begin
        test_reset;
        test_cpu_fill;
        test_jtag_write;
        test_jtag_read;
        test_wrap;
        test_drop_error;
        test_priority;
        test_collision;
        test_pending;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
